// File: rtl/reg_loader_if.sv
// Byte-stream command/response bus plus register-file read/write port for reg_loader.
// slave  : the loader side (consumes in_*, produces out_*, drives the regfile write port and read index).
// master : the environment side (byte source/sink and register file).
interface reg_loader_if #(
    parameter int unsigned DATA_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              we;
    logic [2:0]        c_index;
    logic [DATA_W-1:0] d_input;
    logic [2:0]        a_index;
    logic [DATA_W-1:0] a_output;
    logic              busy;

    modport slave (
        input  in_data, in_valid, out_ready, a_output,
        output in_ready, out_data, out_valid, we, c_index, d_input, a_index, busy
    );

    modport master (
        output in_data, in_valid, out_ready, a_output,
        input  in_ready, out_data, out_valid, we, c_index, d_input, a_index, busy
    );
endinterface

// File: rtl/reg_loader.sv
// Command decoder that turns a byte stream into register-file writes and reads.
// Write: header (bit7=1, bits2:0 index), data high byte, data low byte -> one-cycle we pulse.
// Read : header (bit7=0, bits2:0 index) -> two response bytes, high first, on out_*.
// Ports: clk, reset (synchronous, active-high), bus (reg_loader_if.slave).
module reg_loader #(
    parameter int unsigned DATA_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    reg_loader_if.slave  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        WR_LO,
        WR_COMMIT,
        RD_FETCH,
        RD_HI,
        RD_LO
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   rsp_q, rsp_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    c_index_q, c_index_d;
    logic [DATA_W-1:0]   d_input_q, d_input_d;
    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_data_q, out_data_d;
    logic                in_ready_c;
    logic                in_fire_c;

    // Input is accepted only in the byte-collecting states and never during reset.
    assign in_ready_c = !reset && ((state_q == IDLE) || (state_q == WR_HI) || (state_q == WR_LO));
    assign in_fire_c  = bus.in_valid && in_ready_c;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rsp_d       = rsp_q;
        we_d        = 1'b0;
        c_index_d   = c_index_q;
        d_input_d   = d_input_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (in_fire_c) begin
                    idx_d   = bus.in_data[IDX_W-1:0];
                    state_d = bus.in_data[BYTE_W-1] ? WR_HI : RD_FETCH;
                end
            end
            WR_HI: begin
                if (in_fire_c) begin
                    hi_d    = bus.in_data;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                // Write-port outputs are set up here so they are registered in WR_COMMIT.
                if (in_fire_c) begin
                    lo_d      = bus.in_data;
                    state_d   = WR_COMMIT;
                    we_d      = 1'b1;
                    c_index_d = idx_q;
                    d_input_d = DATA_W'({hi_q, bus.in_data});
                end
            end
            WR_COMMIT: begin
                state_d = IDLE;
            end
            RD_FETCH: begin
                // a_index already carries the latched index, so a_output is valid now.
                rsp_d       = bus.a_output;
                state_d     = RD_HI;
                out_valid_d = 1'b1;
                out_data_d  = bus.a_output[DATA_W-1 -: BYTE_W];
            end
            RD_HI: begin
                out_valid_d = 1'b1;
                if (bus.out_ready) begin
                    state_d    = RD_LO;
                    out_data_d = rsp_q[BYTE_W-1:0];
                end
            end
            RD_LO: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            rsp_q       <= '0;
            we_q        <= 1'b0;
            c_index_q   <= '0;
            d_input_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rsp_q       <= rsp_d;
            we_q        <= we_d;
            c_index_q   <= c_index_d;
            d_input_q   <= d_input_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = (state_q != IDLE);
    assign bus.we        = we_q;
    assign bus.c_index   = c_index_q;
    assign bus.d_input   = d_input_q;
    assign bus.a_index   = idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_reg_loader.sv
// Testbench for reg_loader: directed scenarios, a command table and randomized commands
// checked against a register-array model of the command protocol.
module tb_reg_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_loader_if #(.DATA_W(16)) bus();
    reg_loader #(.DATA_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Environment register file: written by we, read combinationally by a_index.
    logic [15:0] rf [8];
    always @(posedge clk) if (bus.we === 1'b1) rf[bus.c_index] <= bus.d_input;
    assign bus.a_output = rf[bus.a_index];

    // Response sink: forced level or random backpressure.
    logic ready_force = 1'b1;
    logic rand_bp = 1'b0;
    logic rnd_bit = 1'b1;
    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign bus.out_ready = rand_bp ? rnd_bit : ready_force;

    // Monitor: logs writes, response bytes, accepted input bytes; checks response hold.
    logic [18:0] act_we [$];
    logic [7:0]  act_rx [$];
    int          n_acc = 0;
    logic        stall_q = 1'b0;
    logic [7:0]  stall_data = 8'h00;
    always @(posedge clk) begin
        if (bus.we === 1'b1) act_we.push_back({bus.c_index, bus.d_input});
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) n_acc <= n_acc + 1;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) act_rx.push_back(bus.out_data);
        if (stall_q) chk("hold_stable", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, stall_data});
        stall_q    <= (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0) && !reset;
        stall_data <= bus.out_data;
    end

    // Reference model: register contents as the command protocol defines them.
    logic [15:0] mregs [8];

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: waited %0d cycles, required in_ready=1", n);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic [2:0] idx, input logic [15:0] data,
                           input int gap, input logic [3:0] junk,
                           input logic use_exp, input logic [15:0] exp_rd);
        send_byte({wr, junk, idx}, gap);
        if (wr) begin
            send_byte(data[15:8], gap);
            send_byte(data[7:0], gap);
        end
        wait_idle();
        if (wr) begin
            mregs[idx] = data;
            chk("we_count", act_we.size(), 1);
            if (act_we.size() > 0) chk("we_payload", {13'd0, act_we[0]}, {13'd0, idx, data});
            chk("rx_stray", act_rx.size(), 0);
        end else begin
            chk("rx_count", act_rx.size(), 2);
            if (act_rx.size() >= 2) begin
                chk("rd_model", {16'd0, act_rx[0], act_rx[1]}, {16'd0, mregs[idx]});
                if (use_exp) chk("rd_table", {16'd0, act_rx[0], act_rx[1]}, {16'd0, exp_rd});
            end
            chk("we_stray", act_we.size(), 0);
        end
        act_we.delete();
        act_rx.delete();
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  idx;
        logic [15:0] data;
        int          gap;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [10];
    int   n0;

    initial begin
        vecs[0] = '{1'b1, 3'd2, 16'h1234, 0, 16'h0000};
        vecs[1] = '{1'b0, 3'd2, 16'h0000, 0, 16'h1234};
        vecs[2] = '{1'b1, 3'd6, 16'hFFFF, 1, 16'h0000};
        vecs[3] = '{1'b0, 3'd6, 16'h0000, 0, 16'hFFFF};
        vecs[4] = '{1'b1, 3'd0, 16'h0000, 0, 16'h0000};
        vecs[5] = '{1'b0, 3'd0, 16'h0000, 2, 16'h0000};
        vecs[6] = '{1'b1, 3'd2, 16'hA5C3, 1, 16'h0000};
        vecs[7] = '{1'b0, 3'd2, 16'h0000, 2, 16'hA5C3};
        vecs[8] = '{1'b0, 3'd3, 16'h0000, 0, 16'hBEEF};
        vecs[9] = '{1'b0, 3'd6, 16'h0000, 1, 16'hFFFF};

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready_high", bus.in_ready, 1);
        chk("rst_we", bus.we, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_c_index", bus.c_index, 0);
        chk("rst_d_input", bus.d_input, 0);
        chk("rst_a_index", bus.a_index, 0);
        chk("rst_out_data", bus.out_data, 0);

        // Give every register a known value through the DUT.
        for (int i = 0; i < 8; i++)
            run_cmd(1'b1, 3'(i), 16'($urandom), 0, 4'($urandom), 1'b0, 16'h0);

        // Continuous write of 0xBEEF to register 3, with exact commit timing.
        send_byte(8'h83, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        chk("w34_we", bus.we, 1);
        chk("w34_c_index", bus.c_index, 3);
        chk("w34_d_input", bus.d_input, 16'hBEEF);
        @(posedge clk);
        #1;
        chk("w34_we_low", bus.we, 0);
        chk("w34_busy", bus.busy, 0);
        chk("w34_rf3", rf[3], 16'hBEEF);
        chk("w34_we_pulses", act_we.size(), 1);
        act_we.delete();
        mregs[3] = 16'hBEEF;

        // Read of register 3 with the response held back for several cycles.
        ready_force = 1'b0;
        send_byte(8'h03, 0);
        chk("r35_fetch_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("r35_first_valid", bus.out_valid, 1);
        chk("r35_first_data", bus.out_data, 8'hBE);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("r35_stall_valid", bus.out_valid, 1);
            chk("r35_stall_data", bus.out_data, 8'hBE);
        end
        @(negedge clk);
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        chk("r35_lo_valid", bus.out_valid, 1);
        chk("r35_lo_data", bus.out_data, 8'hEF);
        @(posedge clk);
        #1;
        chk("r35_done_valid", bus.out_valid, 0);
        chk("r35_done_busy", bus.busy, 0);
        chk("r35_rx", act_rx.size() == 2 ? {16'd0, act_rx[0], act_rx[1]} : 32'hFFFF_FFFF, 16'hBEEF);
        act_rx.delete();

        // Gapped write bytes.
        send_byte(8'h85, 0);
        send_byte(8'h12, 3);
        send_byte(8'h34, 2);
        wait_idle();
        chk("g36_we_pulses", act_we.size(), 1);
        if (act_we.size() > 0) chk("g36_payload", {13'd0, act_we[0]}, {13'd0, 3'd5, 16'h1234});
        act_we.delete();
        mregs[5] = 16'h1234;

        // Reset in the middle of a write abandons it.
        send_byte(8'h87, 0);
        send_byte(8'hAA, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("r37_in_ready_in_reset", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("r37_busy", bus.busy, 0);
        chk("r37_in_ready", bus.in_ready, 1);
        repeat (4) @(negedge clk);
        chk("r37_no_we", act_we.size(), 0);
        chk("r37_rf7", rf[7], mregs[7]);
        chk("r37_no_rx", act_rx.size(), 0);
        act_we.delete();

        // Write immediately followed by a read of the same register.
        n0 = n_acc;
        send_byte(8'h81, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        wait_idle();
        mregs[1] = 16'h0001;
        chk("b38_we_pulses", act_we.size(), 1);
        if (act_we.size() > 0) chk("b38_payload", {13'd0, act_we[0]}, {13'd0, 3'd1, 16'h0001});
        chk("b38_rx", act_rx.size() == 2 ? {16'd0, act_rx[0], act_rx[1]} : 32'hFFFF_FFFF, 16'h0001);
        chk("b38_accepted", n_acc - n0, 4);
        act_we.delete();
        act_rx.delete();

        // Command table.
        for (int i = 0; i < 10; i++)
            run_cmd(vecs[i].wr, vecs[i].idx, vecs[i].data, vecs[i].gap, 4'($urandom),
                    !vecs[i].wr, vecs[i].exp_rd);

        // Randomized commands with random response backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++)
            run_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    $urandom_range(0, 2), 4'($urandom), 1'b0, 16'h0);
        rand_bp = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_loader.md
REG_LOADER -- requirements
Module: reg_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register data width; only 16 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have port in_data, input, 8, the command byte stream.
REQ-005 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1); a byte transfers on a rising edge with both high.
REQ-006 The block SHALL have ports out_data (output, 8), out_valid (output, 1) and out_ready (input, 1); a byte transfers on a rising edge with both high.
REQ-007 The block SHALL have ports we (output, 1), c_index (output, 3) and d_input (output, 16), the register-file write port.
REQ-008 The block SHALL have ports a_index (output, 3) and a_output (input, 16), the register-file read port; a_output is combinational from a_index.
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-010 Header byte SHALL decode as: bit7 = command (1 write, 0 read); bits6:3 ignored; bits2:0 = register index, latched on acceptance.
REQ-011 Write command SHALL be header, then data high byte, then data low byte.
REQ-012 Read command SHALL be header only; the response is two bytes, high first.
REQ-013 FSM states SHALL be IDLE, WR_HI, WR_LO, WR_COMMIT, RD_FETCH, RD_HI, RD_LO.
REQ-014 in_ready SHALL be 1 in IDLE, WR_HI and WR_LO, and 0 in all other states.
REQ-015 An offered byte with in_ready low SHALL NOT be consumed and SHALL NOT alter state.
REQ-016 IDLE SHALL move to WR_HI on an accepted write header, to RD_FETCH on an accepted read header, and otherwise remain in IDLE.
REQ-017 WR_HI SHALL latch the accepted byte as hi and move to WR_LO; with no accepted byte it SHALL remain in WR_HI indefinitely (no timeout).
REQ-018 WR_LO SHALL latch the accepted byte as lo and move to WR_COMMIT.
REQ-019 In WR_COMMIT, for exactly one cycle, we SHALL be 1, c_index SHALL be the latched index and d_input SHALL be {hi,lo}; next state is IDLE.
REQ-020 we SHALL be 0 in every state other than WR_COMMIT.
REQ-021 Write latency: low byte accepted at edge N -> we high between edges N and N+1 -> register updated at edge N+1.
REQ-022 c_index and d_input SHALL hold their last committed values outside WR_COMMIT.
REQ-023 a_index SHALL always equal the latched index.
REQ-024 RD_FETCH SHALL last one cycle and capture a_output into a 16-bit response buffer at its closing edge; next state is RD_HI.
REQ-025 RD_HI SHALL drive out_valid=1 and out_data=buffer[15:8] and move to RD_LO only when out_ready=1.
REQ-026 RD_LO SHALL drive out_valid=1 and out_data=buffer[7:0] and move to IDLE only when out_ready=1.
REQ-027 out_valid SHALL be 0 outside RD_HI/RD_LO; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 Read latency: header accepted at edge N -> first out_valid at cycle after edge N+1.
REQ-029 Back-to-back commands SHALL be supported: a header is acceptable in the IDLE cycle immediately following WR_COMMIT or the RD_LO handshake.
REQ-030 Write-then-read of the same index SHALL return the newly written value.

Reset
REQ-031 reset=1 at a rising edge SHALL force state IDLE, we=0, out_valid=0, c_index=0, d_input=0, a_index=0, out_data=0, latched index/hi/lo/buffer=0; reset overrides all other inputs.
REQ-032 Reset mid-command SHALL abandon the partial command: no write is issued and no response bytes are emitted.
REQ-033 in_ready SHALL be 0 while reset=1; it becomes 1 in the first cycle after reset deasserts.

Verification
REQ-034 Write: bytes 0x83,0xBE,0xEF with in_valid continuous -> single we pulse, c_index=3, d_input=0xBEEF; register 3 = 0xBEEF.
REQ-035 Read with backpressure: read header 0x03, out_ready low 5 cycles -> out_data=0xBE held stable with out_valid=1, then 0xEF, then busy=0.
REQ-036 Gapped input: 0x85, idle 3 cycles, 0x12, idle 2 cycles, 0x34 -> exactly one we pulse, c_index=5, d_input=0x1234.
REQ-037 Reset mid-write: 0x87,0xAA then reset for 1 cycle -> no we pulse, register 7 unchanged, state IDLE.
REQ-038 Back-to-back: write 0x81,0x00,0x01 immediately followed by read header 0x01 -> response bytes 0x00,0x01; no in_valid byte lost or duplicated.
